// File: rtl/tlb_maint_if.sv
// Command / TLB-port bundle between a requester, the maintenance unit and the TLB array.
// The slave modport is the maintenance unit's view.
interface tlb_maint_if #(
    parameter int TLBNUM = 16
);
    localparam int IW = $clog2(TLBNUM);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [IW-1:0] cmd_index;
    logic [4:0]    cmd_invop;
    logic [88:0]   cmd_data;
    logic          done;
    logic          done_err;
    logic [IW-1:0] r_index;
    logic [88:0]   r_data;
    logic          we;
    logic [IW-1:0] w_index;
    logic [88:0]   w_data;

    modport slave (
        input  cmd_valid, cmd_op, cmd_index, cmd_invop, cmd_data, r_data,
        output cmd_ready, done, done_err, r_index, we, w_index, w_data
    );

    modport master (
        output cmd_valid, cmd_op, cmd_index, cmd_invop, cmd_data, r_data,
        input  cmd_ready, done, done_err, r_index, we, w_index, w_data
    );
endinterface

// File: rtl/tlb_maint_unit.sv
// TLB maintenance sequencer: TLBWR, TLBFILL and INVTLB walks over a single read/write port.
// Define TLB_FILL_LFSR_EN to take the TLBFILL index from an 8-bit LFSR instead of a 4-bit counter.
module tlb_maint_unit #(
    parameter int TLBNUM = 16
) (
    input logic        clk,
    input logic        resetn,
    tlb_maint_if.slave bus
);
    localparam int IW = $clog2(TLBNUM);

    localparam logic [1:0] OP_TLBWR  = 2'd0;
    localparam logic [1:0] OP_INVTLB = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WALK, S_DONE} state_e;

`ifdef TLB_FILL_LFSR_EN
    localparam int          FW       = 8;
    localparam logic [FW-1:0] FILL_RST = 8'h01;
`else
    localparam int          FW       = 4;
    localparam logic [FW-1:0] FILL_RST = '0;
`endif

    state_e        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [IW-1:0] index_q, index_d;
    logic [4:0]    invop_q, invop_d;
    logic [88:0]   data_q, data_d;
    logic [IW-1:0] fill_idx_q, fill_idx_d;
    logic [IW-1:0] walk_q, walk_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          done_q, done_d;
    logic          done_err_q, done_err_d;
    logic          cmd_ready_q, cmd_ready_d;

    logic accept;
    logic illegal_cmd;

    assign accept      = bus.cmd_valid && cmd_ready_q;
    assign illegal_cmd = (bus.cmd_op == OP_RSVD) ||
                         ((bus.cmd_op == OP_INVTLB) && (bus.cmd_invop > 5'd6));

    // Fill source runs every cycle regardless of FSM state.
    always_comb begin
`ifdef TLB_FILL_LFSR_EN
        fill_d = {fill_q[6:0], fill_q[7] ^ fill_q[5] ^ fill_q[4] ^ fill_q[3]};
`else
        fill_d = fill_q + FW'(1);
`endif
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        op_d        = op_q;
        index_d     = index_q;
        invop_d     = invop_q;
        data_d      = data_q;
        fill_idx_d  = fill_idx_q;
        walk_d      = walk_q;
        done_d      = 1'b0;
        done_err_d  = 1'b0;
        cmd_ready_d = cmd_ready_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d        = bus.cmd_op;
                    index_d     = bus.cmd_index;
                    invop_d     = bus.cmd_invop;
                    data_d      = bus.cmd_data;
                    fill_idx_d  = IW'(fill_q);
                    walk_d      = '0;
                    cmd_ready_d = 1'b0;
                    if (illegal_cmd) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                    end else if (bus.cmd_op == OP_INVTLB) begin
                        state_d = S_WALK;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_WALK: begin
                if (walk_q == IW'(TLBNUM - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    walk_d = walk_q + IW'(1);
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!resetn) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            index_q     <= '0;
            invop_q     <= '0;
            data_q      <= '0;
            fill_idx_q  <= '0;
            walk_q      <= '0;
            fill_q      <= FILL_RST;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            index_q     <= index_d;
            invop_q     <= invop_d;
            data_q      <= data_d;
            fill_idx_q  <= fill_idx_d;
            walk_q      <= walk_d;
            fill_q      <= fill_d;
            done_q      <= done_d;
            done_err_q  <= done_err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // INVTLB match against the entry currently on the read port.
    logic [18:0] r_vppn, c_vppn;
    logic        r_e, r_g, asid_eq, va_eq, inv_hit;

    always_comb begin
        r_e     = bus.r_data[88];
        r_g     = bus.r_data[52];
        r_vppn  = bus.r_data[87:69];
        c_vppn  = data_q[87:69];
        asid_eq = (bus.r_data[62:53] == data_q[62:53]);
        va_eq   = (r_vppn[18:10] == c_vppn[18:10]) &&
                  ((bus.r_data[68:63] == 6'd22) || (r_vppn[9:0] == c_vppn[9:0]));
        unique case (invop_q)
            5'd0, 5'd1: inv_hit = 1'b1;
            5'd2:       inv_hit = r_g;
            5'd3:       inv_hit = !r_g;
            5'd4:       inv_hit = !r_g && asid_eq;
            5'd5:       inv_hit = !r_g && asid_eq && va_eq;
            5'd6:       inv_hit = (r_g || asid_eq) && va_eq;
            default:    inv_hit = 1'b0;
        endcase
    end

    // Write port is combinational so a walk can invalidate the entry it reads in the same cycle.
    always_comb begin
        bus.we      = 1'b0;
        bus.w_index = walk_q;
        bus.w_data  = {1'b0, bus.r_data[87:0]};
        unique case (state_q)
            S_WRITE: begin
                bus.we      = 1'b1;
                bus.w_index = (op_q == OP_TLBWR) ? index_q : fill_idx_q;
                bus.w_data  = data_q;
            end
            S_WALK:  bus.we = r_e && inv_hit;
            default: bus.we = 1'b0;
        endcase
    end

    assign bus.r_index   = walk_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.done      = done_q;
    assign bus.done_err  = done_err_q;
endmodule

// File: tb/tb_tlb_maint_unit.sv
// Directed bench for tlb_maint_unit: a behavioural TLB model predicts every cycle's outputs,
// plus literal checks on the key scenarios.
module tb_tlb_maint_unit;
    localparam int N = 16;

    typedef struct {
        bit          we;
        int          idx;
        logic [88:0] data;
        bit          done;
        bit          err;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    tlb_maint_if #(.TLBNUM(N)) bus();
    tlb_maint_unit #(.TLBNUM(N)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    logic [88:0] tlb [N] = '{default: '0};
    logic [88:0] mdl [N] = '{default: '0};
    assign bus.r_data = tlb[bus.r_index];
    always @(posedge clk) if (bus.we) tlb[bus.w_index] <= bus.w_data;

    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0;
    int   rcyc = 0;
    int   we_cnt = 0, done_cnt = 0, err_cnt = 0, last_widx = -1;

    always @(posedge clk or negedge resetn)
        if (!resetn) rcyc = 0;
        else         rcyc = rcyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [88:0] mk(bit e, logic [18:0] vppn, logic [5:0] ps, logic [9:0] asid,
                                       bit g, logic [25:0] lo1, logic [25:0] lo0);
        return {e, vppn, ps, asid, g, lo1, lo0};
    endfunction

    function automatic logic [88:0] pat(int i);
        return mk(1'b1, 19'(32'h400 * (i % 3) + i * 5), (i % 3 == 0) ? 6'd22 : 6'd12,
                  10'(i % 4), i[0], 26'(i * 3 + 1), 26'(i));
    endfunction

    // Which entries an INVTLB of the given op would invalidate.
    function automatic bit inv_match(input logic [4:0] op, input logic [88:0] ent, input logic [88:0] key);
        logic [18:0] ev, kv;
        bit global_pg, asid_ok, va_ok;
        ev        = ent[87:69];
        kv        = key[87:69];
        global_pg = ent[52];
        asid_ok   = (ent[62:53] == key[62:53]);
        if (ent[68:63] == 6'd22) va_ok = ((ev >> 10) == (kv >> 10));
        else                     va_ok = (ev == kv);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return global_pg;
            5'd3:       return !global_pg;
            5'd4:       return !global_pg && asid_ok;
            5'd5:       return !global_pg && asid_ok && va_ok;
            5'd6:       return (global_pg || asid_ok) && va_ok;
            default:    return 1'b0;
        endcase
    endfunction

    // Fill index seen by a command accepted k cycles after reset release.
    function automatic int fill_model(int k);
`ifdef TLB_FILL_LFSR_EN
        logic [7:0] l;
        l = 8'h01;
        repeat (k) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return int'(l) % N;
`else
        return k % N;
`endif
    endfunction

    // Per-cycle comparison against the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                exp_q.delete();
                check("rst_we", 128'(bus.we), 128'(0));
                check("rst_done", 128'(bus.done), 128'(0));
            end else begin
                if (bus.we) begin
                    we_cnt++;
                    last_widx = int'(bus.w_index);
                end
                if (bus.done) done_cnt++;
                if (bus.done && bus.done_err) err_cnt++;
                if (exp_q.size() == 0) begin
                    check("idle_ready", 128'(bus.cmd_ready), 128'(1));
                    check("idle_we", 128'(bus.we), 128'(0));
                    check("idle_done", 128'(bus.done), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("busy_ready", 128'(bus.cmd_ready), 128'(0));
                    check("we", 128'(bus.we), 128'(e.we));
                    if (e.we) begin
                        check("w_index", 128'(bus.w_index), 128'(e.idx));
                        check("w_data", 128'(bus.w_data), 128'(e.data));
                        mdl[e.idx] = e.data;
                    end
                    check("done", 128'(bus.done), 128'(e.done));
                    if (e.done) check("done_err", 128'(bus.done_err), 128'(e.err));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input int idx, input logic [4:0] invop,
                         input logic [88:0] data, input bit wait_done);
        exp_t e;
        int k, n;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_index = 4'(idx);
        bus.cmd_invop = invop;
        bus.cmd_data  = data;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        k = rcyc - 1;
        if (op == 2'd3 || (op == 2'd2 && invop > 5'd6)) begin
            e = '{we: 1'b0, idx: 0, data: '0, done: 1'b1, err: 1'b1};
            exp_q.push_back(e);
        end else begin
            if (op == 2'd2) begin
                for (int i = 0; i < N; i++) begin
                    e = '{we: mdl[i][88] && inv_match(invop, mdl[i], data), idx: i,
                          data: {1'b0, mdl[i][87:0]}, done: 1'b0, err: 1'b0};
                    exp_q.push_back(e);
                end
            end else begin
                e = '{we: 1'b1, idx: (op == 2'd0) ? idx : fill_model(k), data: data,
                      done: 1'b0, err: 1'b0};
                exp_q.push_back(e);
            end
            e = '{we: 1'b0, idx: 0, data: '0, done: 1'b1, err: 1'b0};
            exp_q.push_back(e);
        end
        if (wait_done) begin
            n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("drain", 128'(exp_q.size()), 128'(0));
        end
    endtask

    task automatic load_pat();
        for (int i = 0; i < N; i++) issue(2'd0, i, 5'd0, pat(i), 1'b1);
    endtask

    initial begin
        int w0, d0, e0, any_v, cnt;
        logic [88:0] d5, key;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_index = '0;
        bus.cmd_invop = '0;
        bus.cmd_data  = '0;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 128'(bus.cmd_ready), 128'(1));
        check("reset_we", 128'(bus.we), 128'(0));
        check("reset_done", 128'(bus.done), 128'(0));
        @(posedge clk);
        #2 resetn = 1'b1;

        // TLBFILL accepted on the fourth edge after release.
        repeat (3) @(posedge clk);
        w0 = we_cnt;
        issue(2'd1, 0, 5'd0, mk(1'b1, 19'h1, 6'd12, 10'h1, 1'b0, 26'h5, 26'h6), 1'b1);
        check("fill_we_count", 128'(we_cnt - w0), 128'(1));
`ifndef TLB_FILL_LFSR_EN
        check("fill_index_lit", 128'(last_widx), 128'(3));
`endif

        // TLBWR index 5.
        d5 = mk(1'b1, 19'h12345, 6'd12, 10'h3, 1'b0, 26'h2abcdef, 26'h1234567);
        w0 = we_cnt; d0 = done_cnt; e0 = err_cnt;
        issue(2'd0, 5, 5'd0, d5, 1'b1);
        check("wr_entry5_lit", 128'(tlb[5]), 128'(d5));
        check("wr_index_lit", 128'(last_widx), 128'(5));
        check("wr_done_lit", 128'(done_cnt - d0), 128'(1));
        check("wr_err_lit", 128'(err_cnt - e0), 128'(0));

        // INVTLB op 0 on a fully valid table.
        load_pat();
        w0 = we_cnt;
        issue(2'd2, 0, 5'd0, '0, 1'b1);
        check("inv0_we_count", 128'(we_cnt - w0), 128'(16));
        any_v = 0;
        for (int i = 0; i < N; i++) any_v += int'(tlb[i][88]);
        check("inv0_all_clear", 128'(any_v), 128'(0));

        // op 3 then op 2 split the table by the global bit.
        load_pat();
        w0 = we_cnt;
        issue(2'd2, 0, 5'd3, '0, 1'b1);
        check("inv3_we_count", 128'(we_cnt - w0), 128'(8));
        w0 = we_cnt;
        issue(2'd2, 0, 5'd2, '0, 1'b1);
        check("inv2_we_count", 128'(we_cnt - w0), 128'(8));

        // op 4 (asid 2), op 6, then op 1 clears the rest.
        load_pat();
        w0 = we_cnt;
        issue(2'd2, 0, 5'd4, mk(1'b0, 19'h0, 6'd0, 10'h2, 1'b0, 26'h0, 26'h0), 1'b1);
        check("inv4_we_count", 128'(we_cnt - w0), 128'(4));
        key = mk(1'b0, 19'h819, 6'd0, 10'h1, 1'b0, 26'h0, 26'h0);
        issue(2'd2, 0, 5'd6, key, 1'b1);
        issue(2'd2, 0, 5'd1, '0, 1'b1);

        // op 5: only the non-global 4MB page in asid 3 matches.
        for (int i = 0; i < N; i++) begin
            if (i == 2)
                issue(2'd0, i, 5'd0, mk(1'b1, 19'h007FF, 6'd22, 10'h3, 1'b0, 26'h11, 26'h22), 1'b1);
            else if (i == 7)
                issue(2'd0, i, 5'd0, mk(1'b1, 19'h00400, 6'd12, 10'h3, 1'b1, 26'h33, 26'h44), 1'b1);
            else if (i == 9)
                issue(2'd0, i, 5'd0, mk(1'b0, 19'h00400, 6'd12, 10'h3, 1'b0, 26'h55, 26'h66), 1'b1);
            else
                issue(2'd0, i, 5'd0, '0, 1'b1);
        end
        w0 = we_cnt;
        issue(2'd2, 0, 5'd5, mk(1'b0, 19'h00400, 6'd0, 10'h3, 1'b0, 26'h0, 26'h0), 1'b1);
        check("inv5_we_count", 128'(we_cnt - w0), 128'(1));
        check("inv5_index", 128'(last_widx), 128'(2));
        check("inv5_entry2_e", 128'(tlb[2][88]), 128'(0));
        check("inv5_entry7_e", 128'(tlb[7][88]), 128'(1));

        // Illegal commands: invop 9, invop 7, reserved op.
        w0 = we_cnt; e0 = err_cnt;
        issue(2'd2, 0, 5'd9, '0, 1'b1);
        issue(2'd2, 0, 5'd7, '0, 1'b1);
        issue(2'd3, 4, 5'd0, pat(4), 1'b1);
        check("illegal_we_count", 128'(we_cnt - w0), 128'(0));
        check("illegal_err_count", 128'(err_cnt - e0), 128'(3));

        // Reset during walk index 8 of INVTLB op 0.
        load_pat();
        issue(2'd2, 0, 5'd0, '0, 1'b0);
        repeat (8) @(posedge clk);
        d0 = done_cnt;
        #2 resetn = 1'b0;
        #1 check("abort_we_drop", 128'(bus.we), 128'(0));
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 128'(done_cnt - d0), 128'(0));
        check("abort_ready", 128'(bus.cmd_ready), 128'(1));
        cnt = 0;
        for (int i = 0; i < 8; i++) cnt += int'(tlb[i][88]);
        check("abort_low_cleared", 128'(cnt), 128'(0));
        cnt = 0;
        for (int i = 8; i < N; i++) cnt += (tlb[i] == pat(i)) ? 1 : 0;
        check("abort_high_untouched", 128'(cnt), 128'(8));

        // Unit still operates after the abort.
        issue(2'd0, 12, 5'd0, pat(3), 1'b1);
        for (int i = 0; i < N; i++) check("final_entry", 128'(tlb[i]), 128'(mdl[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tlb_maint_unit.md
TLB_MAINT_UNIT -- requirements
Module: tlb_maint_unit

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, giving the number of TLB entries; IW = clog2(TLBNUM).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 SHALL have port cmd_ready, output, 1 bit: unit idle and accepting.
REQ-006 SHALL have port cmd_op, input, 2 bits: 0=TLBWR, 1=TLBFILL, 2=INVTLB, 3=reserved.
REQ-007 SHALL have port cmd_index, input, IW bits: target entry for TLBWR.
REQ-008 SHALL have port cmd_invop, input, 5 bits: INVTLB op code.
REQ-009 SHALL have port cmd_data, input, 89 bits: packed entry.
- Bit 88 e; 87:69 vppn; 68:63 ps; 62:53 asid; 52 g.
- Bits 51:26 lo1 = {ppn1[51:32], plv1[31:30], mat1[29:28], d1[27], v1[26]}.
- Bits 25:0 lo0, same layout.
- For INVTLB only asid and vppn are used.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port done_err, output, 1 bit: valid with done; 1 = illegal op.
REQ-012 SHALL have port r_index, output, IW bits: TLB read-port index.
REQ-013 SHALL have port r_data, input, 89 bits: combinational TLB read data, same packing as cmd_data.
REQ-014 SHALL have port we, output, 1 bit: TLB write enable.
REQ-015 SHALL have port w_index, output, IW bits: TLB write index.
REQ-016 SHALL have port w_data, output, 89 bits: TLB write data, same packing as cmd_data.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, WALK, DONE; cmd_ready=1 only in IDLE.
REQ-018 SHALL accept a command when cmd_valid & cmd_ready in cycle T and latch cmd_op, cmd_index, cmd_invop and cmd_data.
REQ-019 SHALL on TLBWR/TLBFILL go to WRITE at T+1 and drive we=1 with w_data=latched cmd_data.
- TLBWR: w_index = latched cmd_index.
- TLBFILL: w_index = fill index sampled at T.
- Then DONE at T+2 (done=1, done_err=0), then IDLE at T+3.
REQ-020 SHALL on INVTLB with invop 0..6 walk entries 0..TLBNUM-1, one per cycle, in cycles T+1..T+TLBNUM.
- r_index = walk counter; DONE at T+TLBNUM+1.
REQ-021 SHALL in a walk cycle, when r_data.e=1 and the match rule holds, drive we=1, w_index=r_index, w_data=r_data with bit 88 cleared; otherwise we=0.
REQ-022 SHALL use these INVTLB match rules:
- op 0/1: all entries.
- op 2: g=1.
- op 3: g=0.
- op 4: g=0 and asid equal.
- op 5: g=0, asid equal, VA equal.
- op 6: (g=1 or asid equal) and VA equal.
REQ-023 SHALL define VA equal as vppn[18:10] equal AND (entry ps==22 OR vppn[9:0] equal).
REQ-024 SHALL treat INVTLB with invop >6, or cmd_op=3, as illegal: no write occurs, DONE at T+1 with done_err=1.
REQ-025 SHALL drive we=0 in IDLE and DONE; r_index, w_index and w_data are don't-care when we=0.
REQ-026 SHALL keep the fill source free-running every cycle, independent of FSM state.
- Without the macro: 4-bit counter, +1 per cycle, wraps 15->0.
- Fill index = low IW bits of the fill source.
REQ-027 SHALL ignore cmd_valid while busy; commands are neither queued nor lost silently, since cmd_ready=0.

Reset
REQ-028 SHALL on resetn=0 immediately force state IDLE, with we=0, done=0, done_err=0 and cmd_ready=1 (after release).
- Walk counter resets to 0; fill source resets to 0, or to 8'h01 with the macro.
REQ-029 SHALL abort any in-progress walk or write on reset; entries already invalidated stay invalidated and no done is issued.

Configuration
REQ-030 SHALL, when macro TLB_FILL_LFSR_EN is defined, replace the fill counter with an 8-bit Fibonacci LFSR.
- Polynomial x^8+x^6+x^5+x^4+1, seed 8'h01, steps every cycle.
- Fill index = lfsr[IW-1:0].
- Without the macro, REQ-026 counter behaviour applies.

Verification
REQ-031 SHALL cover TLBWR with cmd_index=5, cmd_data.e=1, vppn=19'h12345 -> we=1, w_index=5, w_data=cmd_data at T+1; done=1, done_err=0 at T+2; cmd_ready=1 at T+3.
REQ-032 SHALL cover INVTLB op 0 with all 16 entries e=1 -> 16 consecutive we pulses with w_index 0..15 and e=0; done at T+17.
REQ-033 SHALL cover INVTLB op 5 with asid=10'h3, vppn=19'h00400, where entry 2 (g=0, asid 3, ps 22, vppn 19'h007FF) and entry 7 (g=1) are valid -> only entry 2 is written.
REQ-034 SHALL cover INVTLB op 9 -> done=1, done_err=1 at T+1, no we.
REQ-035 SHALL cover resetn=0 asserted at walk index 8 of INVTLB op 0 -> we drops immediately, no done, cmd_ready=1 after release, entries 8..15 untouched.
REQ-036 SHALL cover TLBFILL issued 3 cycles after reset release, without the macro -> w_index=3.
